// File: rtl/conv_result_ddr_packer_if.sv
// Bus bundle between the ConvUnit result stream, the DDR write port and the packer.
// The master side drives beats and DDR ready; the slave side is the packer itself.
interface conv_result_ddr_packer_if #(
  parameter int unsigned IN_WIDTH     = 144,
  parameter int unsigned DDR_WR_WIDTH = 256,
  parameter int unsigned CNT_WIDTH    = 32
);
  logic [IN_WIDTH-1:0]     MAC_data_in;
  logic                    MAC_data_valid_in;
  logic                    flush_in;
  logic [DDR_WR_WIDTH-1:0] DDR_data_out;
  logic                    DDR_valid_out;
  logic                    DDR_ready_in;
  logic                    DDR_last_out;
  logic                    flush_done;
  logic                    overflow;
  logic [CNT_WIDTH-1:0]    word_count_out;

  modport master (
    output MAC_data_in, MAC_data_valid_in, flush_in, DDR_ready_in,
    input  DDR_data_out, DDR_valid_out, DDR_last_out, flush_done, overflow, word_count_out
  );

  modport slave (
    input  MAC_data_in, MAC_data_valid_in, flush_in, DDR_ready_in,
    output DDR_data_out, DDR_valid_out, DDR_last_out, flush_done, overflow, word_count_out
  );
endinterface

// File: rtl/conv_result_ddr_packer.sv
// Packs 144-bit ConvUnit result beats densely into 256-bit DDR write words,
// buffered by a first-word-fall-through FIFO with an end-of-layer flush.
module conv_result_ddr_packer #(
  parameter int unsigned IN_WIDTH        = 144,
  parameter int unsigned DDR_WR_WIDTH    = 256,
  parameter int unsigned FIFO_ADDR_DEPTH = 4,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  conv_result_ddr_packer_if.slave bus
);

  localparam int unsigned STAGE_W    = IN_WIDTH + DDR_WR_WIDTH;
  localparam int unsigned FILL_W     = $clog2(STAGE_W + 1);
  localparam int unsigned FIFO_DEPTH = 1 << FIFO_ADDR_DEPTH;
  localparam int unsigned LVL_W      = FIFO_ADDR_DEPTH + 1;
  localparam int unsigned ENTRY_W    = DDR_WR_WIDTH + 1;

  typedef enum logic {
    ST_PACK  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [STAGE_W-1:0]       r_stage;
  logic [STAGE_W-1:0]       w_stage_nxt;
  logic [STAGE_W-1:0]       w_stage_base;
  logic [STAGE_W-1:0]       w_appended;
  logic [FILL_W-1:0]        r_fill;
  logic [FILL_W-1:0]        w_fill_nxt;
  logic [FILL_W-1:0]        w_fill_base;
  logic [FILL_W-1:0]        w_fill_sum;
  logic                     r_pending;
  logic                     w_pending_nxt;
  logic                     r_flush_done;
  logic                     w_flush_done_nxt;
  logic                     w_push_req;
  logic                     w_push_last;
  logic [DDR_WR_WIDTH-1:0]  w_push_data;

  logic [ENTRY_W-1:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_DEPTH-1:0] r_wr_ptr;
  logic [FIFO_ADDR_DEPTH-1:0] r_rd_ptr;
  logic [LVL_W-1:0]           r_mem_cnt;
  logic [LVL_W-1:0]           w_level;
  logic                       w_pop;
  logic                       w_full;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_load;

  logic [DDR_WR_WIDTH-1:0] r_out_data;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic                    r_overflow;
  logic [CNT_WIDTH-1:0]    r_word_cnt;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_PACK;
    else       r_state <= w_state_nxt;
  end

  // Next state, flush action and beat packing
  always_comb begin
    w_state_nxt      = r_state;
    w_pending_nxt    = r_pending | bus.flush_in;
    w_flush_done_nxt = 1'b0;
    w_stage_base     = r_stage;
    w_fill_base      = r_fill;
    w_push_req       = 1'b0;
    w_push_last      = 1'b0;
    w_push_data      = '0;

    case (r_state)
      ST_PACK: begin
        if (r_pending && !bus.MAC_data_valid_in) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_state_nxt      = ST_PACK;
        w_flush_done_nxt = 1'b1;
        w_pending_nxt    = bus.flush_in;
        w_stage_base     = '0;
        w_fill_base      = '0;
        // Bits above fill are always zero, so the low word is already zero-padded.
        if (r_fill != '0) begin
          w_push_req  = 1'b1;
          w_push_last = 1'b1;
          w_push_data = r_stage[DDR_WR_WIDTH-1:0];
        end
      end
      default: w_state_nxt = ST_PACK;
    endcase

    w_appended  = w_stage_base | (STAGE_W'(bus.MAC_data_in) << w_fill_base);
    w_fill_sum  = w_fill_base + FILL_W'(IN_WIDTH);
    w_stage_nxt = w_stage_base;
    w_fill_nxt  = w_fill_base;

    if (bus.MAC_data_valid_in) begin
      if (w_fill_sum >= FILL_W'(DDR_WR_WIDTH)) begin
        w_push_req  = 1'b1;
        w_push_last = 1'b0;
        w_push_data = w_appended[DDR_WR_WIDTH-1:0];
        w_stage_nxt = w_appended >> DDR_WR_WIDTH;
        w_fill_nxt  = w_fill_sum - FILL_W'(DDR_WR_WIDTH);
      end else begin
        w_stage_nxt = w_appended;
        w_fill_nxt  = w_fill_sum;
      end
    end
  end

  // FIFO occupancy counts the output register, so a pop frees a slot for a same-cycle push
  always_comb begin
    w_pop   = r_out_valid & bus.DDR_ready_in;
    w_level = r_mem_cnt + LVL_W'(r_out_valid);
    w_full  = (w_level == LVL_W'(FIFO_DEPTH));
    w_push  = w_push_req & (~w_full | w_pop);
    w_drop  = w_push_req & w_full & ~w_pop;
    w_load  = (r_mem_cnt != '0) & (~r_out_valid | w_pop);
  end

  // Staging, flush bookkeeping and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stage      <= '0;
      r_fill       <= '0;
      r_pending    <= 1'b0;
      r_flush_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_cnt   <= '0;
    end else begin
      r_stage      <= w_stage_nxt;
      r_fill       <= w_fill_nxt;
      r_pending    <= w_pending_nxt;
      r_flush_done <= w_flush_done_nxt;
      if (w_drop) r_overflow <= 1'b1;
      if (w_push) r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_push_last, w_push_data};
  end

  // FIFO pointers and registered head
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_ADDR_DEPTH'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + FIFO_ADDR_DEPTH'(1);
      case ({w_push, w_load})
        2'b10:   r_mem_cnt <= r_mem_cnt + LVL_W'(1);
        2'b01:   r_mem_cnt <= r_mem_cnt - LVL_W'(1);
        default: r_mem_cnt <= r_mem_cnt;
      endcase
      if (w_load) begin
        r_out_data  <= r_mem[r_rd_ptr][DDR_WR_WIDTH-1:0];
        r_out_last  <= r_mem[r_rd_ptr][DDR_WR_WIDTH];
        r_out_valid <= 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign bus.DDR_data_out   = r_out_data;
  assign bus.DDR_valid_out  = r_out_valid;
  assign bus.DDR_last_out   = r_out_last;
  assign bus.flush_done     = r_flush_done;
  assign bus.overflow       = r_overflow;
  assign bus.word_count_out = r_word_cnt;

endmodule

// File: tb/tb_conv_result_ddr_packer.sv
// Directed bench for conv_result_ddr_packer: packing, flush, overflow, ready
// stalls and mid-stream reset against a bit-stream reference of the beats.
module tb_conv_result_ddr_packer;

  localparam int unsigned IN_W = 144;
  localparam int unsigned DW   = 256;
  localparam int unsigned CW   = 32;
  localparam int unsigned NB   = 64;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  conv_result_ddr_packer_if #(.IN_WIDTH(IN_W), .DDR_WR_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  conv_result_ddr_packer #(
    .IN_WIDTH(IN_W), .DDR_WR_WIDTH(DW), .FIFO_ADDR_DEPTH(4), .CNT_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_vec   = 0;
  int n_err   = 0;
  int n_flush = 0;
  logic [DW:0]     rx_q[$];
  logic [IN_W-1:0] beats [NB];
  logic            prev_hold = 1'b0;
  logic [DW:0]     prev_word = '0;

  task automatic check(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] mk_beat(input int i, input int seed);
    logic [IN_W-1:0] b;
    for (int c = 0; c < 18; c++) b[c*8 +: 8] = 8'(seed*37 + i*18 + c + 1);
    return b;
  endfunction

  // Expected word k of the little-endian concatenation of beats[]
  function automatic logic [DW-1:0] ref_word(input int k);
    logic [NB*IN_W-1:0] s;
    for (int i = 0; i < NB; i++) s[i*IN_W +: IN_W] = beats[i];
    return s[k*DW +: DW];
  endfunction

  // Output monitor: collects handshaken words and checks hold-under-stall
  always @(negedge clk) begin
    if (!rstn) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 264'(bus.DDR_valid_out), 264'(1));
        check("hold_word", 264'({bus.DDR_last_out, bus.DDR_data_out}), 264'(prev_word));
      end
      if (bus.DDR_valid_out && bus.DDR_ready_in) rx_q.push_back({bus.DDR_last_out, bus.DDR_data_out});
      if (bus.flush_done) n_flush <= n_flush + 1;
      prev_hold <= bus.DDR_valid_out && !bus.DDR_ready_in;
      prev_word <= {bus.DDR_last_out, bus.DDR_data_out};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.MAC_data_valid_in = 1'b0;
    bus.flush_in = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    rx_q.delete();
  endtask

  task automatic send(input int n, input int seed, input bit toggle);
    for (int i = 0; i < n; i++) begin
      beats[i] = mk_beat(i, seed);
      bus.MAC_data_valid_in = 1'b1;
      bus.MAC_data_in = beats[i];
      if (toggle) bus.DDR_ready_in = ~bus.DDR_ready_in;
      tick();
    end
    bus.MAC_data_valid_in = 1'b0;
  endtask

  task automatic drain(input int n, input bit toggle);
    int b = 0;
    while (rx_q.size() < n && b < 300) begin
      if (toggle) bus.DDR_ready_in = ~bus.DDR_ready_in;
      tick();
      b++;
    end
    bus.DDR_ready_in = 1'b1;
    repeat (6) tick();
  endtask

  task automatic check_words(input string tag, input int n);
    check({tag, "_count"}, 264'(rx_q.size()), 264'(n));
    for (int k = 0; k < n && k < rx_q.size(); k++)
      check($sformatf("%s_w%0d", tag, k), 264'(rx_q[k]), 264'({1'b0, ref_word(k)}));
  endtask

  initial begin
    int f0;
    rstn = 1'b0;
    bus.MAC_data_in = '0;
    bus.MAC_data_valid_in = 1'b0;
    bus.flush_in = 1'b0;
    bus.DDR_ready_in = 1'b1;
    tick();
    tick();
    check("rst_valid", 264'(bus.DDR_valid_out), 264'(0));
    check("rst_last", 264'(bus.DDR_last_out), 264'(0));
    check("rst_data", 264'(bus.DDR_data_out), 264'(0));
    check("rst_done", 264'(bus.flush_done), 264'(0));
    check("rst_ovf", 264'(bus.overflow), 264'(0));
    check("rst_cnt", 264'(bus.word_count_out), 264'(0));
    rstn = 1'b1;
    tick();

    // 16 back-to-back beats give exactly 9 full words
    rx_q.delete();
    send(16, 0, 1'b0);
    drain(9, 1'b0);
    check_words("s1", 9);
    if (rx_q.size() >= 9) begin
      check("s1_W0", 264'(rx_q[0]), 264'({1'b0, beats[1][111:0], beats[0]}));
      check("s1_W1", 264'(rx_q[1]), 264'({1'b0, beats[3][79:0], beats[2], beats[1][143:112]}));
      check("s1_W8_top", 264'(rx_q[8][255:144]), 264'(beats[15][143:32]));
    end
    check("s1_cnt", 264'(bus.word_count_out), 264'(9));

    // Single beat then flush: zero-padded last word
    rx_q.delete();
    f0 = n_flush;
    beats[0] = {18{8'hA5}};
    bus.MAC_data_valid_in = 1'b1;
    bus.MAC_data_in = beats[0];
    tick();
    bus.MAC_data_valid_in = 1'b0;
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    drain(1, 1'b0);
    check("s2_count", 264'(rx_q.size()), 264'(1));
    if (rx_q.size() >= 1) check("s2_word", 264'(rx_q[0]), 264'({1'b1, 112'h0, beats[0]}));
    check("s2_done", 264'(n_flush - f0), 264'(1));
    check("s2_cnt", 264'(bus.word_count_out), 264'(10));

    // Flush with nothing staged: done pulse only
    rx_q.delete();
    f0 = n_flush;
    bus.flush_in = 1'b1;
    tick();
    bus.flush_in = 1'b0;
    repeat (8) tick();
    check("s2e_done", 264'(n_flush - f0), 264'(1));
    check("s2e_count", 264'(rx_q.size()), 264'(0));
    check("s2e_cnt", 264'(bus.word_count_out), 264'(10));

    // Flush coinciding with a beat: beat packed first, flush on next idle cycle
    rx_q.delete();
    beats[0] = mk_beat(0, 3);
    beats[1] = mk_beat(1, 3);
    bus.MAC_data_valid_in = 1'b1;
    bus.MAC_data_in = beats[0];
    tick();
    bus.MAC_data_in = beats[1];
    bus.flush_in = 1'b1;
    tick();
    bus.MAC_data_valid_in = 1'b0;
    bus.flush_in = 1'b0;
    drain(2, 1'b0);
    check("s3_count", 264'(rx_q.size()), 264'(2));
    if (rx_q.size() >= 2) begin
      check("s3_W0", 264'(rx_q[0]), 264'({1'b0, beats[1][111:0], beats[0]}));
      check("s3_W1", 264'(rx_q[1]), 264'({1'b1, 224'h0, beats[1][143:112]}));
    end
    check("s3_cnt", 264'(bus.word_count_out), 264'(12));

    // 32 beats with DDR stalled: 16 stored, 2 dropped
    do_reset();
    bus.DDR_ready_in = 1'b0;
    send(32, 4, 1'b0);
    repeat (4) tick();
    check("s4_ovf", 264'(bus.overflow), 264'(1));
    check("s4_cnt", 264'(bus.word_count_out), 264'(16));
    check("s4_valid", 264'(bus.DDR_valid_out), 264'(1));
    bus.DDR_ready_in = 1'b1;
    drain(16, 1'b0);
    check_words("s4", 16);
    check("s4_ovf_sticky", 264'(bus.overflow), 264'(1));

    // Ready toggling every cycle
    rx_q.delete();
    bus.DDR_ready_in = 1'b1;
    send(16, 5, 1'b1);
    drain(9, 1'b1);
    check_words("s5", 9);
    check("s5_cnt", 264'(bus.word_count_out), 264'(25));

    // Asynchronous reset mid-stream with a word queued and fill = 176
    rx_q.delete();
    bus.DDR_ready_in = 1'b0;
    send(3, 6, 1'b0);
    tick();
    check("s6_pre_valid", 264'(bus.DDR_valid_out), 264'(1));
    check("s6_pre_ovf", 264'(bus.overflow), 264'(1));
    #2;
    rstn = 1'b0;
    #1;
    check("s6_valid", 264'(bus.DDR_valid_out), 264'(0));
    check("s6_ovf", 264'(bus.overflow), 264'(0));
    check("s6_cnt", 264'(bus.word_count_out), 264'(0));
    check("s6_last", 264'(bus.DDR_last_out), 264'(0));
    tick();
    rstn = 1'b1;
    bus.DDR_ready_in = 1'b1;
    tick();
    rx_q.delete();
    send(16, 0, 1'b0);
    drain(9, 1'b0);
    check_words("s6r", 9);
    check("s6r_cnt", 264'(bus.word_count_out), 264'(9));
    check("s6r_ovf", 264'(bus.overflow), 264'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
